// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matrix-multiply controller.
//   state_t  - controller FSM states (LOAD, MAC, OUT)
//   DIM_DEF  - default matrix dimension
//   EW_DEF   - default unsigned operand element width
//   AW_DEF   - default result width, wide enough for DIM*(2^EW-1)^2
//   idx_w()  - counter width for a range of n values, never less than 1 bit
package matmul_pkg;

    localparam int DIM_DEF = 2;
    localparam int EW_DEF  = 8;
    localparam int AW_DEF  = 2 * EW_DEF + $clog2(DIM_DEF);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: unsigned multiply-accumulate for one result element.
//   clk, rst_n - clock, asynchronous active-low reset
//   a, b       - EW-bit unsigned factors
//   clr        - clear the accumulator (wins over en)
//   en         - add a*b to the accumulator this edge
//   acc        - AW-bit running sum
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            // Factors widened first so the product is never truncated.
            acc <= acc + AW'(a) * AW'(b);
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: loads two DIM x DIM unsigned matrices as a stream (A row-major,
// then B row-major), computes C = A*B one element at a time and streams C out
// row-major with a valid/ready handshake.
//   clk, rst_n          - clock, asynchronous active-low reset
//   ena                 - global enable; low freezes everything and masks handshakes
//   in_valid, in_data   - operand stream; in_ready high only while loading
//   out_valid, out_data - result stream; out_ready from the consumer
//   busy                - low only when idle in LOAD with nothing loaded
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DIM = DIM_DEF,
    parameter int EW  = EW_DEF,
    parameter int AW  = 2 * EW + $clog2(DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          in_valid,
    input  logic [EW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);

    localparam int NA   = DIM * DIM;
    localparam int NOPS = 2 * NA;
    localparam int LW   = idx_w(NOPS);
    localparam int IW   = idx_w(DIM);

    localparam logic [LW-1:0] LAST_LD = LW'(NOPS - 1);
    localparam logic [IW-1:0] LAST_IX = IW'(DIM - 1);

    state_t        state, state_next;
    logic [LW-1:0] load_cnt;
    logic [IW-1:0] i_idx, j_idx, k_idx;
    logic [EW-1:0] ops [NOPS];   // A in [0, NA), B in [NA, 2*NA)

    logic          accept, load_done, out_hs, last_k, last_ij;
    logic [LW-1:0] a_idx, b_idx;
    logic          mac_clr, mac_en;
    logic [AW-1:0] acc;

    // ena gates both handshakes here, so every qualified event below is
    // already stalled when ena is low.
    assign in_ready  = ena && (state == ST_LOAD);
    assign out_valid = ena && (state == ST_OUT);
    assign busy      = !((state == ST_LOAD) && (load_cnt == '0));
    assign out_data  = acc;

    assign accept    = in_valid && in_ready;
    assign load_done = accept && (load_cnt == LAST_LD);
    assign out_hs    = out_valid && out_ready;
    assign last_k    = (k_idx == LAST_IX);
    assign last_ij   = (i_idx == LAST_IX) && (j_idx == LAST_IX);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (load_done)      state_next = ST_MAC;
            ST_MAC:  if (ena && last_k)  state_next = ST_OUT;
            ST_OUT:  if (out_hs)         state_next = last_ij ? ST_LOAD : ST_MAC;
            default:                     state_next = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            // NOTE: operand storage is reset explicitly so a reset discards
            // any partial load; this keeps it out of RAM macros on purpose.
            for (int n = 0; n < NOPS; n++) ops[n] <= '0;
        end else begin
            if (accept) begin
                ops[load_cnt] <= in_data;
                load_cnt      <= load_done ? '0 : load_cnt + 1'b1;
            end
            if (ena && (state == ST_MAC)) begin
                k_idx <= last_k ? '0 : k_idx + 1'b1;
            end
            if (out_hs) begin
                if (j_idx == LAST_IX) begin
                    j_idx <= '0;
                    i_idx <= (i_idx == LAST_IX) ? '0 : i_idx + 1'b1;
                end else begin
                    j_idx <= j_idx + 1'b1;
                end
            end
        end
    end

    // A[i][k] and B[k][j] in the flat operand store.
    always_comb begin
        a_idx = LW'(i_idx) * LW'(DIM) + LW'(k_idx);
        b_idx = LW'(NA) + LW'(k_idx) * LW'(DIM) + LW'(j_idx);
    end

    // Accumulator starts clean for each element: on the final operand accept
    // and on every result handshake.
    assign mac_clr = load_done || out_hs;
    assign mac_en  = ena && (state == ST_MAC);

    matmul_mac #(
        .EW (EW),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (ops[a_idx]),
        .b     (ops[b_idx]),
        .clr   (mac_clr),
        .en    (mac_en),
        .acc   (acc)
    );

endmodule
